// File: rtl/tt_sweep_capture.sv
// Sweeps a 4-input gate through all 16 vectors and captures its output as a 16-bit truth-table word.
// Optional compare/miscompare counter is enabled with `define TT_COMPARE_EN.
module tt_sweep_capture #(
   parameter int SETTLE_CYCLES = 2,
   parameter int TT_W          = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [3:0]      dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            tt_valid,
   input  logic            tt_ready,
   output logic [TT_W-1:0] tt_data,
   input  logic [TT_W-1:0] expected,
   output logic            match
);

   // state  | meaning
   // IDLE   | waiting for start
   // APPLY  | drive vector k onto dut_in, load settle counter
   // SETTLE | hold dut_in while the gate output settles
   // SAMPLE | capture dut_out into bit 15-k
   // OUT    | present tt_data until the consumer accepts it
   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, OUT} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_k;
   logic [3:0]      r_cnt;
   logic [3:0]      r_dut_in;
   logic [TT_W-1:0] r_sr;
   logic [TT_W-1:0] r_tt_data;
   logic [TT_W-1:0] w_sr_smp;
   logic            w_last;

   assign w_last = (r_k == 4'd15);

   always_comb begin
      w_sr_smp = r_sr;
      w_sr_smp[4'd15 - r_k] = dut_out;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = APPLY;
         APPLY:   w_state_nxt = SETTLE;
         SETTLE:  if (r_cnt == 4'd0) w_state_nxt = SAMPLE;
         SAMPLE:  w_state_nxt = w_last ? OUT : APPLY;
         OUT:     if (tt_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k       <= 4'd0;
         r_cnt     <= 4'd0;
         r_dut_in  <= 4'd0;
         r_sr      <= '0;
         r_tt_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // clearing here keeps stale bits of an earlier sweep out of the result
               if (start) begin
                  r_k  <= 4'd0;
                  r_sr <= '0;
               end
            end
            APPLY: begin
               r_dut_in <= r_k;
               r_cnt    <= SETTLE_LOAD;
            end
            SETTLE: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            SAMPLE: begin
               r_sr <= w_sr_smp;
               if (w_last) r_tt_data <= w_sr_smp;
               else        r_k       <= r_k + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign dut_in   = r_dut_in;
   assign busy     = (r_state != IDLE);
   assign tt_valid = (r_state == OUT);
   assign tt_data  = r_tt_data;

`ifdef TT_COMPARE_EN
   logic       r_match;
   logic [3:0] r_miscmp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_match  <= 1'b0;
         r_miscmp <= 4'd0;
      end else begin
         if (r_state == SAMPLE && w_last) r_match <= (w_sr_smp == expected);
         if (r_state == OUT && tt_ready && !r_match && r_miscmp != 4'd15)
            r_miscmp <= r_miscmp + 4'd1;
      end
   end

   assign match = r_match & tt_valid;
`else
   logic w_unused_expected;
   assign w_unused_expected = ^expected;
   assign match = 1'b0;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: gate models, handshake stall, mid-sweep reset, SETTLE_CYCLES=1.
module tb_tt_sweep_capture;
   logic        clk = 1'b0;
   logic        rst, start, dut_out, busy, tt_valid, tt_ready, match;
   logic [3:0]  dut_in;
   logic [15:0] tt_data, expected;
   logic        start1, dut_out1, busy1, tt_valid1, match1;
   logic [3:0]  dut_in1;
   logic [15:0] tt_data1;
   logic        tt_ready1;
   int          checks = 0;
   int          errors = 0;
   int          gate_sel;
   logic [15:0] gate_tt;

   always #5 clk = ~clk;

   // gate models: 0 = 0x30CE netlist, 1 = constant 1, 2 = input _0 (dut_in[3])
   always_comb begin
      dut_out = gate_tt[4'd15 - dut_in];
      if (gate_sel == 1) dut_out = 1'b1;
      else if (gate_sel == 2) dut_out = dut_in[3];
   end
   assign dut_out1 = gate_tt[4'd15 - dut_in1];

   tt_sweep_capture #(.SETTLE_CYCLES(2), .TT_W(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
      .busy(busy), .tt_valid(tt_valid), .tt_ready(tt_ready), .tt_data(tt_data),
      .expected(expected), .match(match));

   tt_sweep_capture #(.SETTLE_CYCLES(1), .TT_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
      .busy(busy1), .tt_valid(tt_valid1), .tt_ready(tt_ready1), .tt_data(tt_data1),
      .expected(expected), .match(match1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_sweep(input logic [15:0] exp_tt, input string tag);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
      end while (!tt_valid && cyc < 300);
      check({tag, "_latency"}, 32'(cyc), 32'd65);
      check({tag, "_data"}, {16'h0, tt_data}, {16'h0, exp_tt});
      check({tag, "_busy"}, {31'h0, busy}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start1 = 1'b0; tt_ready = 1'b1; tt_ready1 = 1'b1;
      expected = 16'h0000; gate_sel = 0; gate_tt = 16'h30CE;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dut_in", {28'h0, dut_in}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_valid", {31'h0, tt_valid}, 32'h0);
      check("rst_data", {16'h0, tt_data}, 32'h0);
      check("rst_match", {31'h0, match}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // 0x30CE gate, consumer always ready
      do_sweep(16'h30CE, "g30ce");
      check("g30ce_match_off", {31'h0, match}, 32'h0);
      step();
      check("g30ce_busy_after", {31'h0, busy}, 32'h0);
      check("g30ce_valid_after", {31'h0, tt_valid}, 32'h0);
      check("g30ce_data_kept", {16'h0, tt_data}, 32'h30CE);

      gate_sel = 1;
      do_sweep(16'hFFFF, "const1");
      step();
      gate_sel = 2;
      do_sweep(16'h00FF, "in0");
      step();
      check("in0_busy_after", {31'h0, busy}, 32'h0);

      // consumer stalls 10 cycles; start inside the window is ignored
      gate_sel = 0;
      tt_ready = 1'b0;
      do_sweep(16'h30CE, "stall");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = (i == 4);
         step();
         check("stall_valid", {31'h0, tt_valid}, 32'h1);
         check("stall_data", {16'h0, tt_data}, 32'h30CE);
      end
      @(negedge clk);
      start = 1'b0;
      tt_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      check("xfer_valid", {31'h0, tt_valid}, 32'h0);
      check("xfer_busy", {31'h0, busy}, 32'h0);
      step();
      check("xfer_start_ignored", {31'h0, busy}, 32'h0);

      // reset at cycle 30 of a sweep (dut_in is 7 at that point)
      @(negedge clk);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      check("mid_dut_in_before", {28'h0, dut_in}, 32'h7);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_dut_in", {28'h0, dut_in}, 32'h0);
      check("mid_rst_busy", {31'h0, busy}, 32'h0);
      check("mid_rst_valid", {31'h0, tt_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      do_sweep(16'h30CE, "after_rst");
      step();

      // SETTLE_CYCLES=1 instance: each vector held 3 cycles, valid at cycle 49
      @(negedge clk);
      start1 = 1'b1;
      for (int e = 1; e <= 49; e++) begin
         step();
         start1 = 1'b0;
         if (e >= 2) check("s1_dut_in", {28'h0, dut_in1}, 32'((e - 2) / 3));
         check("s1_valid", {31'h0, tt_valid1}, (e == 49) ? 32'd1 : 32'd0);
      end
      check("s1_data", {16'h0, tt_data1}, 32'h30CE);
      step();
      check("s1_busy_after", {31'h0, busy1}, 32'h0);

`ifdef TT_COMPARE_EN
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      expected = 16'h30CE;
      do_sweep(16'h30CE, "cmp_ok");
      check("cmp_ok_match", {31'h0, match}, 32'h1);
      step();
      check("cmp_ok_match_idle", {31'h0, match}, 32'h0);
      check("cmp_ok_cnt", {28'h0, u_dut.r_miscmp}, 32'h0);
      expected = 16'h30CF;
      do_sweep(16'h30CE, "cmp_bad");
      check("cmp_bad_match", {31'h0, match}, 32'h0);
      step();
      check("cmp_bad_cnt", {28'h0, u_dut.r_miscmp}, 32'h1);
      for (int i = 0; i < 15; i++) begin
         do_sweep(16'h30CE, "cmp_rep");
         step();
      end
      check("cmp_sat16", {28'h0, u_dut.r_miscmp}, 32'hF);
      do_sweep(16'h30CE, "cmp_extra");
      step();
      check("cmp_sat17", {28'h0, u_dut.r_miscmp}, 32'hF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
